// File: rtl/dcache_pkg.sv
// Shared types and sizes for the dcache tile-port arbiter.
package dcache_pkg;

  localparam int unsigned TILE_WIDTH = 288;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned CNT_W      = 4;

  // Requester identity; also used as the read-response tag (NONE/LD/DMA only).
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_ST   = 2'd2,
    REQ_DMA  = 2'd3
  } req_e;

endpackage

// File: rtl/dcache_starve_ctr.sv
// Saturating starve counter: counts consecutive denied cycles of one
// requester and raises a boost once the count reaches STARVE_LIMIT.
module dcache_starve_ctr
  import dcache_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_grant,
  output logic             o_boost,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_count;

  // Count denied cycles, clear on transfer or idle, saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!i_valid || i_grant) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_boost = i_valid && (r_count >= LIMIT);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Single-port tile memory arbiter between regfile load, regfile store and
// DMA, with starvation boosting and a one-cycle read-response router.
module dcache_port_arbiter
  import dcache_pkg::*;
#(
  parameter int unsigned TILE_WIDTH   = dcache_pkg::TILE_WIDTH,
  parameter int unsigned ADDR_W       = dcache_pkg::ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // regfile load
  input  logic                  ld_valid,
  input  logic [ADDR_W-1:0]     ld_addr,
  output logic                  ld_ready,
  output logic                  ld_rvalid,
  output logic [TILE_WIDTH-1:0] ld_rdat,
  // regfile store
  input  logic                  st_valid,
  input  logic [ADDR_W-1:0]     st_addr,
  input  logic [TILE_WIDTH-1:0] st_dat,
  output logic                  st_ready,
  // DMA
  input  logic                  dma_valid,
  input  logic                  dma_we,
  input  logic [ADDR_W-1:0]     dma_addr,
  input  logic [TILE_WIDTH-1:0] dma_wdat,
  output logic                  dma_ready,
  output logic                  dma_rvalid,
  output logic [TILE_WIDTH-1:0] dma_rdat,
  // tile memory
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [TILE_WIDTH-1:0] mem_wdat,
  input  logic [TILE_WIDTH-1:0] mem_rdat,
  // pipeline stall
  output logic                  freeze
);

  logic             w_ld_boost;
  logic             w_dma_boost;
  logic [CNT_W-1:0] w_ld_count;
  logic [CNT_W-1:0] w_dma_count;
  logic             w_ld_rsp;
  logic             w_dma_rsp;
  req_e             w_gnt;
  req_e             w_tag_next;
  req_e             r_tag;

  dcache_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_ld_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_valid (ld_valid),
    .i_grant (ld_ready),
    .o_boost (w_ld_boost),
    .o_count (w_ld_count)
  );

  dcache_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_dma_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_valid (dma_valid),
    .i_grant (dma_ready),
    .o_boost (w_dma_boost),
    .o_count (w_dma_count)
  );

  // Pick the winner: boosted DMA, boosted load, then store > DMA > load.
  always_comb begin
    w_gnt = REQ_NONE;
    if (dma_valid && w_dma_boost) begin
      w_gnt = REQ_DMA;
    end else if (ld_valid && w_ld_boost) begin
      w_gnt = REQ_LD;
    end else if (st_valid) begin
      w_gnt = REQ_ST;
    end else if (dma_valid) begin
      w_gnt = REQ_DMA;
    end else if (ld_valid) begin
      w_gnt = REQ_LD;
    end
  end

  assign ld_ready  = (w_gnt == REQ_LD);
  assign st_ready  = (w_gnt == REQ_ST);
  assign dma_ready = (w_gnt == REQ_DMA);
  assign freeze    = (ld_valid && !ld_ready) || (st_valid && !st_ready);

  // Drive the memory command from the winner; held quiet while in reset.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wdat = '0;
    if (reset) begin
      case (w_gnt)
        REQ_ST: begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = st_addr;
          mem_wdat = st_dat;
        end
        REQ_DMA: begin
          mem_en   = 1'b1;
          mem_we   = dma_we;
          mem_addr = dma_addr;
          mem_wdat = dma_wdat;
        end
        REQ_LD: begin
          mem_en   = 1'b1;
          mem_addr = ld_addr;
        end
        default: ;
      endcase
    end
  end

  // Tag the port owed a read response next cycle.
  always_comb begin
    w_tag_next = REQ_NONE;
    if (w_gnt == REQ_LD) begin
      w_tag_next = REQ_LD;
    end else if (w_gnt == REQ_DMA && !dma_we) begin
      w_tag_next = REQ_DMA;
    end
  end

  // Response tag register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag <= REQ_NONE;
    end else begin
      r_tag <= w_tag_next;
    end
  end

  // Responses are also masked by reset so a read granted just before reset
  // never surfaces.
  assign w_ld_rsp   = reset && (r_tag == REQ_LD);
  assign w_dma_rsp  = reset && (r_tag == REQ_DMA);
  assign ld_rvalid  = w_ld_rsp;
  assign dma_rvalid = w_dma_rsp;
  assign ld_rdat    = w_ld_rsp  ? mem_rdat : '0;
  assign dma_rdat   = w_dma_rsp ? mem_rdat : '0;

endmodule
